// File: rtl/clk_div_pkg.sv
// Shared types and default sizing for the clock divider bank.
package clk_div_pkg;

    // Per-channel divider state.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } chan_state_t;

    localparam int DEFAULT_NCH = 4;
    localparam int DEFAULT_DW  = 8;

endpackage : clk_div_pkg

// File: rtl/clk_div_chan.sv
// One 50%-duty clock divider channel with glitch-free start/stop,
// a tick strobe on every bclk rising edge and a bank-wide sync input.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DW = DEFAULT_DW
) (
    input  logic          mclk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [DW-1:0] div_i,
    input  logic          sync_i,
    output logic          bclk_o,
    output logic          tick_o,
    output logic          running_o
);

    chan_state_t   state_q, state_d;
    logic [DW-1:0] cnt_q,   cnt_d;
    logic [DW-1:0] half_q,  half_d;
    logic          bclk_q,  bclk_d;
    logic          tick_q,  tick_d;
    logic          at_edge;

    // The current half-period ends when the counter reaches the latched ratio.
    assign at_edge = (cnt_q == half_q);

    // Next-state logic: sync/start, counting, and the stop handshake.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path
        // leaves it unassigned; that is what keeps this block latch-free.
        state_d = state_q;
        cnt_d   = cnt_q;
        half_d  = half_q;
        bclk_d  = bclk_q;
        tick_d  = 1'b0;

        if (sync_i && en_i) begin
            // Realign: start a fresh high phase regardless of current state.
            state_d = RUN;
            cnt_d   = '0;
            half_d  = div_i;
            bclk_d  = 1'b1;
            tick_d  = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (en_i) begin
                        state_d = RUN;
                        cnt_d   = '0;
                        half_d  = div_i;
                        bclk_d  = 1'b1;
                        tick_d  = 1'b1;
                    end else begin
                        cnt_d  = '0;
                        bclk_d = 1'b0;
                    end
                end
                RUN, STOPPING: begin
                    if (!en_i && !bclk_q) begin
                        // Low phase: stopping here cannot shorten a high phase.
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        if (at_edge) begin
                            bclk_d = ~bclk_q;
                            tick_d = ~bclk_q;
                            cnt_d  = '0;
                            half_d = div_i;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end

                        if (en_i) begin
                            state_d = RUN;
                        end else if (at_edge && bclk_q) begin
                            // High phase just completed: park low.
                            state_d = IDLE;
                            cnt_d   = '0;
                        end else begin
                            state_d = STOPPING;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    bclk_d  = 1'b0;
                end
            endcase
        end
    end

    // State registers; reset truncates the output immediately.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            bclk_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge value of its inputs, independent of statement order.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            bclk_q  <= bclk_d;
            tick_q  <= tick_d;
        end
    end

    assign bclk_o    = bclk_q;
    assign tick_o    = tick_q;
    assign running_o = (state_q != IDLE);

endmodule : clk_div_chan

// File: rtl/clk_div_bank.sv
// Bank of NCH independent clock dividers sharing mclk and a sync pulse.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NCH = DEFAULT_NCH,
    parameter int DW  = DEFAULT_DW
) (
    input  logic              mclk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    en,
    input  logic [NCH*DW-1:0] div,
    input  logic              sync,
    output logic [NCH-1:0]    bclk,
    output logic [NCH-1:0]    tick,
    output logic [NCH-1:0]    running
);

    // One divider per channel; the top only slices div and fans out sync.
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clk_div_chan #(
            .DW(DW)
        ) u_chan (
            .mclk      (mclk),
            .rst_n     (rst_n),
            .en_i      (en[i]),
            .div_i     (div[i*DW +: DW]),
            .sync_i    (sync),
            .bclk_o    (bclk[i]),
            .tick_o    (tick[i]),
            .running_o (running[i])
        );
    end

endmodule : clk_div_bank

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised bank of NCH independent, registered clock dividers driven from one master clock `mclk`. It replaces the single-channel pass-through buffer. Each channel adds the following:
- a programmable 50%-duty divide ratio;
- glitch-free start and stop;
- a one-cycle tick strobe;
- a bank-wide phase-alignment pulse.

It sits at the clock-generation level and feeds derived clocks, and their matching `mclk`-domain enables, to downstream blocks.

## Interface
- `NCH`, 4: number of divider channels.
- `DW`, 8: width of each channel's ratio field and internal counter.

- `mclk`  in  1  master clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  NCH  per-channel run request, sampled every `mclk`.
- `div`  in  NCH*DW  per-channel half-period minus one; channel i uses `div[i*DW +: DW]`.
- `sync`  in  1  one-cycle pulse that realigns all enabled channels.
- `bclk`  out  NCH  divided clocks, driven directly from flops.
- `tick`  out  NCH  one-`mclk` pulse coincident with each `bclk` rising edge.
- `running`  out  NCH  1 while the channel is not IDLE.

## Operation
- Output period is 2*(div+1) `mclk` cycles with 50% duty.
  - div=0 gives `mclk`/2.
  - div=2^DW-1 gives `mclk`/2^(DW+1).
  - There is no divide-by-1 mode.
- Per-channel state: IDLE, RUN, STOPPING. Per-channel registers:
  - `cnt` (DW bits);
  - `half` (DW bits), the latched copy of `div`;
  - `bclk`, `tick`.
- Reset (async, any time): every output is 0, `cnt`=0, `half`=0, state is IDLE. A reset mid-period truncates the output immediately; no completion of the current phase is required.
- IDLE:
  - `en`=1 sampled → `bclk`←1, `tick`←1, `cnt`←0, `half`←`div`, state→RUN.
  - Otherwise everything holds at 0.
- RUN and STOPPING, counting:
  - If `cnt`==`half`: `bclk` toggles, `cnt`←0, and `half`←`div` (a ratio change takes effect only at a toggle boundary).
  - Otherwise `cnt`←`cnt`+1.
  - `tick`←1 only on a 0→1 toggle.
- RUN, `en`=0 sampled:
  - If `bclk`=0: state→IDLE at once; `cnt`←0; `bclk` stays 0.
  - If `bclk`=1: state→STOPPING and counting continues.
- STOPPING:
  - On the 1→0 toggle, state→IDLE and `cnt`←0.
  - `en`=1 sampled → state→RUN with no disturbance to `cnt` or `bclk`.
  - No channel ever stops with `bclk` high or with a shortened high phase.
- `sync`=1 on a cycle:
  - Every channel with `en`=1 is forced to `bclk`←1, `tick`←1, `cnt`←0, `half`←`div`, state→RUN.
  - This applies from any state, and `sync` has priority over counting and stop handling.
  - Channels with `en`=0 ignore `sync`.
  - `sync` may shorten one low phase. That is the only permitted duty disturbance.
- Channels are fully independent except for the shared `sync`.

## Timing
- `en` rising in cycle k → `bclk`=1 and `tick`=1 visible after edge k+1 (1-cycle latency).
- `tick` is high for exactly one `mclk` cycle per `bclk` period.
- `running` is 1 in RUN and STOPPING.
- A `div` change is invisible until the next `bclk` toggle, so the current half-period always completes at the old ratio.
- Stop latency from `en` falling: at most div+1 cycles, and 1 cycle if `bclk` is low.
- There are no combinational paths from any input to any output.

## Structure
- Package `clk_div_pkg`:
  - `chan_state_t` enum (IDLE, RUN, STOPPING);
  - default `DW` and `NCH` constants.
- Sub-module `clk_div_chan` (one channel, parameter `DW`), instantiated NCH times by a generate loop in `clk_div_bank`.
- The top level only slices `div` and fans out `sync`.

## Test plan
- **Reset and start:** `rst_n`=0 then 1, en[0]=1, div[0]=0 → bclk[0] toggles every cycle (period 2), tick[0] high every second cycle, other channels stay 0.
- **Ratios:** div = 0, 1, 3, 255 on channels 0–3 → measured periods 2, 4, 8, 512 `mclk` with 50% duty, checked via `$realtime` edge deltas.
- **Glitch-free stop:**
  - div=3, `en` dropped 1 cycle after a `bclk` rise → high phase still lasts 4 cycles, then IDLE, and `running` falls on the same edge.
  - `en` dropped during a low phase → IDLE next edge.
- **Ratio change:** div changed 3→1 mid-high-phase → current high lasts 4 cycles, all following phases last 2.
- **Sync:** channels at div=2 and div=5 running out of phase, then a `sync` pulse → both `bclk` rise and `tick` on the same edge; the disabled channel stays 0.
- **Async reset:** `rst_n` asserted mid-high-phase, between clock edges → all `bclk`, `tick`, `running` go 0 immediately, and a restart after release behaves as in the reset-and-start test.
